// File: rtl/z80bus_master_arb.sv
// Two-port round-robin Z80-style bus master: grants one requester, then runs a single
// memrd/memwr/iord/iowr cycle (IDLE -> ADDR -> STRB -> RECOV) with wait_n stretching and timeout.
module z80bus_master_arb #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned WAIT_MAX      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [1:0]  cmd0_i,
  input  logic [1:0]  cmd1_i,
  input  logic [15:0] addr0_i,
  input  logic [15:0] addr1_i,
  input  logic [7:0]  wdata0_i,
  input  logic [7:0]  wdata1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [7:0]  rdata_o,
  output logic        mreq_n_o,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  output logic [15:0] a_o,
  output logic [7:0]  dout_o,
  output logic        doe_o,
  input  logic [7:0]  din_i,
  input  logic        wait_n_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_STRB  = 2'd2;
  localparam logic [1:0] ST_RECOV = 2'd3;

  localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES);
  localparam logic [7:0] WAIT_LIM  = 8'(WAIT_MAX);

  logic [1:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        port_q, port_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d;
  logic        rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        finish_s, abort_s;
  logic        gnt_s;

  // With both requesting, the port that did not win last time gets the bus.
  assign gnt_s = (req0_i && req1_i) ? ~rr_q : req1_i;

  // Next-state and next-output logic; a/dout double as the latched address and write data.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    port_d   = port_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    mreq_n_d = mreq_n_q;
    iorq_n_d = iorq_n_q;
    rd_n_d   = rd_n_q;
    wr_n_d   = wr_n_q;
    a_d      = a_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    rdata_d  = rdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    finish_s = 1'b0;
    abort_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mreq_n_d = 1'b1;
        iorq_n_d = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        doe_d    = 1'b0;
        if (req0_i || req1_i) begin
          port_d  = gnt_s;
          rr_d    = gnt_s;
          cmd_d   = gnt_s ? cmd1_i : cmd0_i;
          a_d     = gnt_s ? addr1_i : addr0_i;
          dout_d  = gnt_s ? wdata1_i : wdata0_i;
          doe_d   = gnt_s ? cmd1_i[0] : cmd0_i[0];
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        mreq_n_d = cmd_q[1];
        iorq_n_d = ~cmd_q[1];
        rd_n_d   = cmd_q[0];
        wr_n_d   = ~cmd_q[0];
        cnt_d    = 4'd1;
        wcnt_d   = 8'd0;
        state_d  = ST_STRB;
      end
      ST_STRB: begin
        if (cnt_q < STRB_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (wait_n_i) begin
          finish_s = 1'b1;
        end else if ((WAIT_LIM != 8'd0) && (wcnt_q == WAIT_LIM)) begin
          finish_s = 1'b1;
          abort_s  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_RECOV: begin
        doe_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        mreq_n_d = 1'b1;
        iorq_n_d = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        doe_d    = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Strobe release: report to the latched port, capture read data (0xFF on timeout).
    if (finish_s) begin
      mreq_n_d = 1'b1;
      iorq_n_d = 1'b1;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      state_d  = ST_RECOV;
      done0_d  = ~port_q;
      done1_d  = port_q;
      err0_d   = abort_s & ~port_q;
      err1_d   = abort_s & port_q;
      if (!cmd_q[0]) begin
        rdata_d = abort_s ? 8'hFF : din_i;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      done0_d = 1'b0;
      done1_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      port_q   <= 1'b0;
      cmd_q    <= 2'd0;
      cnt_q    <= 4'd0;
      wcnt_q   <= 8'd0;
      mreq_n_q <= 1'b1;
      iorq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_q      <= 16'h0000;
      dout_q   <= 8'h00;
      doe_q    <= 1'b0;
      rdata_q  <= 8'h00;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      port_q   <= port_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      mreq_n_q <= mreq_n_d;
      iorq_n_q <= iorq_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      rdata_q  <= rdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign mreq_n_o = mreq_n_q;
  assign iorq_n_o = iorq_n_q;
  assign rd_n_o   = rd_n_q;
  assign wr_n_o   = wr_n_q;
  assign a_o      = a_q;
  assign dout_o   = dout_q;
  assign doe_o    = doe_q;
  assign rdata_o  = rdata_q;
  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign err0_o   = err0_q;
  assign err1_o   = err1_q;

endmodule
